// File: rtl/mdu_scheduler.sv
// Multiply/divide sequencer beside the execute stage: runs multi-cycle mult/div,
// owns HI/LO, stalls the pipeline while occupied and produces the MDout value.
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;

  logic        op_valid, op_muldiv, accept;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    op_valid  = (E_mdop != 4'd0) && (E_mdop <= 4'd8);
    op_muldiv = (E_mdop != 4'd0) && (E_mdop <= 4'd4);
    accept    = op_muldiv && !busy_q && !cancel;
    stall     = op_valid && busy_q && !cancel;
  end

  // Datapath works on the latched operands; sgn_q selects signed interpretation.
  always_comb begin
    prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
    a_neg  = sgn_q & a_q[31];
    b_neg  = sgn_q & b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    // Magnitude division sidesteps the signed overflow case 0x80000000 / -1.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d   = E_rs_val;
          b_d   = E_rt_val;
          sgn_d = (E_mdop == 4'd1) || (E_mdop == 4'd3);
          if (E_mdop <= 4'd2) begin
            state_d = StMult;
            cnt_d   = MultLoad;
          end else begin
            state_d = StDiv;
            cnt_d   = DivLoad;
          end
        end else if (!cancel && (E_mdop == 4'd5)) begin
          hi_d = E_rs_val;
        end else if (!cancel && (E_mdop == 4'd6)) begin
          lo_d = E_rs_val;
        end
      end
      StMult, StDiv: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          if (state_q == StMult) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    case (E_mdop)
      4'd7:    md_out = hi_q;
      4'd8:    md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed scenarios plus random ops, checked every cycle
// against a transaction-level HI/LO model with a remaining-busy-cycles count.
module tb_mdu_scheduler;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  E_mdop = '0;
  logic [31:0] E_rs_val = '0;
  logic [31:0] E_rt_val = '0;
  logic        cancel = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo, md_out;

  int errors = 0;
  int checks = 0;

  mdu_scheduler #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_mdop  (E_mdop),
    .E_rs_val(E_rs_val),
    .E_rt_val(E_rt_val),
    .cancel  (cancel),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO plus the op in flight.
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0;
  int          m_rem = 0;

  task automatic commit();
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    case (m_op)
      4'd1: begin
        sp = longint'($signed(m_a)) * longint'($signed(m_b));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      4'd2: begin
        up = {32'd0, m_a} * {32'd0, m_b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      4'd3: if (m_b != 0) begin
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_rem = 0;
    end else if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) commit();
    end else if (!cancel) begin
      if (E_mdop >= 1 && E_mdop <= 4) begin
        m_op  = E_mdop;
        m_a   = E_rs_val;
        m_b   = E_rt_val;
        m_rem = (E_mdop <= 2) ? MultN : DivN;
      end else if (E_mdop == 5) begin
        m_hi = E_rs_val;
      end else if (E_mdop == 6) begin
        m_lo = E_rs_val;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Compare process: inputs change just after posedge, so negedge sees settled values.
  logic        e_busy, e_stall;
  logic [31:0] e_md;
  always @(negedge clk) begin
    e_busy  = (m_rem != 0);
    e_stall = (E_mdop >= 1) && (E_mdop <= 8) && e_busy && !cancel;
    e_md    = (E_mdop == 7) ? m_hi : (E_mdop == 8) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (!e_stall) chk("md_out", md_out, e_md);
  end

  task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic c);
    E_mdop   = op;
    E_rs_val = rs;
    E_rt_val = rt;
    cancel   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  logic [31:0] pick [4];

  initial begin
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_md_out", md_out, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // multu 0xFFFFFFFF * 2
    cyc(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
    idle(MultN);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_hi", hi, 32'h1);
    chk("t1_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 with mflo held in E
    cyc(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
    for (int i = 0; i < DivN; i++) cyc(4'd8, 32'd0, 32'd0, 1'b0);
    chk("t2_stall", {31'd0, stall}, 32'd0);
    chk("t2_md_out", md_out, 32'hFFFF_FFFD);
    chk("t2_hi", hi, 32'hFFFF_FFFF);
    idle(1);

    // cancelled mult, then a real one
    cyc(4'd1, 32'd3, 32'd4, 1'b1);
    chk("t3_cancel_busy", {31'd0, busy}, 32'd0);
    chk("t3_cancel_lo", lo, 32'hFFFF_FFFD);
    cyc(4'd1, 32'd3, 32'hFFFF_FFFC, 1'b0);
    idle(MultN);
    chk("t3_hi", hi, 32'hFFFF_FFFF);
    chk("t3_lo", lo, 32'hFFFF_FFF4);

    // mthi stalled behind a divu
    cyc(4'd4, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < DivN; i++) cyc(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    chk("t4_divu_hi", hi, 32'd2);
    chk("t4_divu_lo", lo, 32'd14);
    cyc(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    chk("t4_mthi", hi, 32'h1234_5678);
    chk("t4_lo_kept", lo, 32'd14);

    // divu by zero, then signed overflow divide
    cyc(4'd5, 32'hAAAA_0000, 32'd0, 1'b0);
    cyc(4'd6, 32'h0000_BBBB, 32'd0, 1'b0);
    cyc(4'd4, 32'd5, 32'd0, 1'b0);
    idle(DivN);
    chk("t5_dz_hi", hi, 32'hAAAA_0000);
    chk("t5_dz_lo", lo, 32'h0000_BBBB);
    cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DivN);
    chk("t5_ovf_lo", lo, 32'h8000_0000);
    chk("t5_ovf_hi", hi, 32'h0);

    // reset in the middle of a div
    cyc(4'd5, 32'h5555_5555, 32'd0, 1'b0);
    cyc(4'd6, 32'h5555_5555, 32'd0, 1'b0);
    cyc(4'd3, 32'd100, 32'd3, 1'b0);
    idle(2);
    cyc(4'd7, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(DivN + 2);
    chk("t6_after_hi", hi, 32'd0);
    chk("t6_after_lo", lo, 32'd0);

    // random traffic, with corner operands mixed in
    pick[0] = 32'h0;
    pick[1] = 32'h8000_0000;
    pick[2] = 32'hFFFF_FFFF;
    pick[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs, rt;
      rs = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      cyc(4'($urandom_range(0, 15)), rs, rt, ($urandom_range(0, 7) == 0));
    end
    idle(DivN + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
Sequencing controller for the shared multiply/divide resource. It sits beside the execute stage and produces the MDout value that the EX/MEM register captures. It accepts mult/div/mthi/mtlo/mfhi/mflo operations from the E stage and runs multi-cycle multiply and divide operations. While the resource is occupied it raises a stall toward the pipeline, and it drops E-stage operations that an interrupt or exception flush annuls.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
E_mdop  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
E_rs_val  input  32  forwarded rs operand (dividend/multiplicand, mthi/mtlo source)
E_rt_val  input  32  forwarded rt operand (divisor/multiplier)
cancel  input  1  E-stage instruction annulled this cycle (IntReq/exception/eret flush)
busy  output  1  a mult/div is in flight
stall  output  1  freeze F/D/E; insert a bubble into EX/MEM
hi  output  32  architectural HI
lo  output  32  architectural LO
md_out  output  32  mfhi -> hi, mflo -> lo, otherwise 0 (feeds MDout)

Behaviour:
- Reset values: state IDLE, counter 0, busy 0, stall 0, hi 0, lo 0, md_out 0. Reset has priority over everything and aborts any in-flight op with no HI/LO write.
- States:
  - IDLE to MULT when accept with op 1 or 2.
  - IDLE to DIV when accept with op 3 or 4.
  - MULT/DIV to IDLE at the edge where the counter equals 1.
- Counter: width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
  - Loaded with MULT_CYCLES or DIV_CYCLES on accept.
  - Decrements each cycle in MULT/DIV.
- busy = (state != IDLE), registered. It is high for exactly N cycles following the accept edge.
- stall = (E_mdop in 1..8) && busy && !cancel, combinational. A stalled op stays in E and is re-presented the next cycle.
- accept = (E_mdop in 1..4) && !busy && !cancel, sampled at the rising edge.
  - Operands and op kind are latched at the accept edge; later E_rs_val/E_rt_val changes are ignored.
- Result commit: hi/lo are written at the edge that returns the state to IDLE. From the next cycle busy is 0 and the new hi/lo are visible, so a back-to-back mfhi is released that cycle.
- mult: signed 64-bit product, HI = [63:32], LO = [31:0]. multu: unsigned product.
- div: signed, quotient truncates toward zero into LO, remainder into HI with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- divu: unsigned, LO = quotient, HI = remainder.
- Divide by zero: full DIV_CYCLES busy, HI and LO unchanged at completion.
- mthi/mtlo: when !busy && !cancel, hi (or lo) <= E_rs_val at the edge, with no busy cycles. If busy, the op stalls.
- mfhi/mflo: md_out is combinational from the current hi/lo. It is valid only when stall = 0.
- cancel:
  - Blocks accept, mthi/mtlo writes and stall for the current E op.
  - Never aborts an already-accepted mult/div, which still commits. An op accepted before the flush is architecturally committed.
- Simultaneous completion and new op in E: busy is still 1 in the completion cycle, so the new op stalls one cycle. It is accepted the cycle after.
- Only one op can be in flight; no queueing.

Test Plan:
1. multu E_rs_val=0xFFFFFFFF, E_rt_val=0x00000002 -> busy high for 5 cycles. At the 5th edge hi=0x00000001, lo=0xFFFFFFFE. Next cycle busy=0.
2. div 0xFFFFFFF9 (-7) / 0x00000002, then mflo held in E -> stall=1 for 10 cycles. Then stall=0 and md_out=0xFFFFFFFD. hi=0xFFFFFFFF.
3. mult with cancel=1 in the same cycle -> no accept, busy stays 0, hi/lo unchanged. Repeat with cancel=0 one cycle later -> normal 5-cycle run.
4. mthi 0x12345678 presented during an active divu -> stall until completion. Divu result is written first, then hi=0x12345678 one edge later; lo keeps the divu quotient.
5. divu by 0 with hi=0xAAAA0000, lo=0x0000BBBB -> 10 busy cycles, hi/lo unchanged. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
6. Assert reset at cycle 4 of a div (hi=lo=0x55555555 beforehand) -> immediately busy=0, stall=0, hi=lo=0. No later write occurs.
